hilo_unit: RTL and testbench

Multiply/divide issue and HI/LO register stage placed between the execute stage and the shared multiply/divide engine. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests and launches one engine operation at a time. Stalls the pipeline until the engine reports completion, then commits the 64-bit result into architectural HI/LO. Drives `hi`/`lo` to the execute stage for MFHI/MFLO.

---
 rtl/md_pkg.sv | 24 ++
 rtl/hilo_unit.sv | 143 ++++++++++++++
 tb/tb_hilo_unit.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide issue stage: request codes,
// FSM states and the default datapath width.
package md_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_MULT  = 3'b001,
        OP_MULTU = 3'b010,
        OP_DIV   = 3'b011,
        OP_DIVU  = 3'b100,
        OP_MTHI  = 3'b101,
        OP_MTLO  = 3'b110,
        OP_NOP7  = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } md_state_e;

endpackage

// File: rtl/hilo_unit.sv
// Multiply/divide issue stage with architectural HI/LO: launches one engine
// operation at a time, stalls execute until completion, then commits HI/LO.
module hilo_unit #(
    parameter int DATA_W = md_pkg::DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  op_valid,
    input  logic [2:0]            op,
    input  logic [DATA_W-1:0]     op_a,
    input  logic [DATA_W-1:0]     op_b,
    output logic                  stall,
    output logic                  md_start,
    output logic                  md_signed,
    output logic                  md_is_div,
    output logic [DATA_W-1:0]     md_op1,
    output logic [DATA_W-1:0]     md_op2,
    input  logic [2*DATA_W-1:0]   md_result,
    input  logic                  md_end,
    output logic [DATA_W-1:0]     hi,
    output logic [DATA_W-1:0]     lo
);
    import md_pkg::*;

    md_state_e state_q, state_d;

    logic              start_q, start_d;
    logic              signed_q, signed_d;
    logic              isDiv_q, isDiv_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    logic isMulDiv, isDivOp, isSignedOp, divByZero;
    logic accept, launch, commit, wrHi, wrLo;

    always_comb begin
        isMulDiv   = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
        isDivOp    = (op == OP_DIV) || (op == OP_DIVU);
        isSignedOp = (op == OP_MULT) || (op == OP_DIV);
        divByZero  = isDivOp && (op_b == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // In BUSY a completion wins over a flush: either way the engine is done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (launch) state_d = BUSY;
            BUSY:    if (md_end) state_d = IDLE;
                     else if (flush) state_d = DRAIN;
            DRAIN:   if (md_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept = 1'b0;
        launch = 1'b0;
        commit = 1'b0;
        wrHi   = 1'b0;
        wrLo   = 1'b0;
        stall  = 1'b0;
        case (state_q)
            IDLE: begin
                accept = op_valid && !flush;
                launch = accept && isMulDiv && !divByZero;
                wrHi   = accept && (op == OP_MTHI);
                wrLo   = accept && (op == OP_MTLO);
                stall  = launch;
            end
            BUSY: begin
                commit = md_end && !flush;
                stall  = 1'b1;
            end
            DRAIN: begin
                stall  = op_valid;
            end
            default: ;
        endcase
        if (reset) stall = 1'b0;
    end

    always_comb begin
        start_d  = launch;
        signed_d = signed_q;
        isDiv_d  = isDiv_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (launch) begin
            signed_d = isSignedOp;
            isDiv_d  = isDivOp;
            op1_d    = op_a;
            op2_d    = op_b;
        end
        if (commit) begin
            hi_d = md_result[2*DATA_W-1:DATA_W];
            lo_d = md_result[DATA_W-1:0];
        end
        if (wrHi) hi_d = op_a;
        if (wrLo) lo_d = op_a;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            start_q  <= 1'b0;
            signed_q <= 1'b0;
            isDiv_q  <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            start_q  <= start_d;
            signed_q <= signed_d;
            isDiv_q  <= isDiv_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign md_start  = start_q;
    assign md_signed = signed_q;
    assign md_is_div = isDiv_q;
    assign md_op1    = op1_q;
    assign md_op2    = op2_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit: expected engine launches and HI/LO updates are
// queued by the stimulus and consumed by an independent monitor.
module tb_hilo_unit;
    import md_pkg::*;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset, flush, op_valid;
    logic [2:0]     op;
    logic [W-1:0]   op_a, op_b;
    logic           stall, md_start, md_signed, md_is_div;
    logic [W-1:0]   md_op1, md_op2;
    logic [2*W-1:0] md_result;
    logic           md_end;
    logic [W-1:0]   hi, lo;

    int vectors     = 0;
    int miscompares = 0;
    bit monitorOn   = 1'b0;

    typedef struct {
        logic         sgn;
        logic         isDiv;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } launch_t;

    launch_t        launchQ[$];
    logic [2*W-1:0] hiloQ[$];

    hilo_unit #(.DATA_W(W)) dut (
        .clk(clk), .reset(reset), .flush(flush), .op_valid(op_valid), .op(op),
        .op_a(op_a), .op_b(op_b), .stall(stall), .md_start(md_start),
        .md_signed(md_signed), .md_is_div(md_is_div), .md_op1(md_op1),
        .md_op2(md_op2), .md_result(md_result), .md_end(md_end), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op_valid = v;
        op       = o;
        op_a     = a;
        op_b     = b;
    endtask

    // Monitor: every md_start pulse and every HI/LO change must match the queue head.
    initial begin
        logic [2*W-1:0] prev;
        launch_t        e;
        logic [2*W-1:0] h;
        wait (monitorOn);
        @(negedge clk);
        prev = {hi, lo};
        forever begin
            @(negedge clk);
            if (md_start === 1'b1) begin
                if (launchQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected md_start: got 1, expected 0");
                end else begin
                    e = launchQ.pop_front();
                    checkOutput("md_signed", md_signed, e.sgn);
                    checkOutput("md_is_div", md_is_div, e.isDiv);
                    checkOutput("md_op1", md_op1, e.a);
                    checkOutput("md_op2", md_op2, e.b);
                end
            end
            if ({hi, lo} !== prev) begin
                if (hiloQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected hilo change: got %0h, expected %0h", {hi, lo}, prev);
                end else begin
                    h = hiloQ.pop_front();
                    checkOutput("hilo update", {hi, lo}, h);
                end
                prev = {hi, lo};
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; md_end = 1'b0; md_result = '0;
        applyStimulus(1'b0, OP_NOP, '0, '0);
        tick(); tick();
        @(negedge clk);
        checkOutput("reset stall", stall, 0);
        checkOutput("reset hi", hi, 0);
        checkOutput("reset lo", lo, 0);
        checkOutput("reset md_start", md_start, 0);
        tick();
        reset = 1'b0;
        monitorOn = 1'b1;

        // MTHI then MTLO on consecutive cycles
        tick();
        applyStimulus(1'b1, OP_MTHI, 32'h1234, '0);
        hiloQ.push_back(64'h00001234_00000000);
        @(negedge clk); checkOutput("mthi stall", stall, 0);
        tick();
        applyStimulus(1'b1, OP_MTLO, 32'h5678, '0);
        hiloQ.push_back(64'h00001234_00005678);
        @(negedge clk); checkOutput("mthi hi at T+1", hi, 32'h1234);
        checkOutput("mtlo stall", stall, 0);
        tick();
        applyStimulus(1'b0, OP_NOP, '0, '0);
        @(negedge clk); checkOutput("mtlo lo at T+2", lo, 32'h5678);

        // Signed MULT, engine finishes at T+4
        tick();
        applyStimulus(1'b1, OP_MULT, 32'hFFFFFFFE, 32'd3);
        launchQ.push_back('{1'b1, 1'b0, 32'hFFFFFFFE, 32'd3});
        hiloQ.push_back(64'hFFFFFFFF_FFFFFFFA);
        @(negedge clk); checkOutput("mult stall T", stall, 1);
        checkOutput("mult md_start T", md_start, 0);
        tick();
        applyStimulus(1'b0, OP_NOP, '0, '0);
        @(negedge clk); checkOutput("mult md_start T+1", md_start, 1);
        checkOutput("mult stall T+1", stall, 1);
        tick();
        @(negedge clk); checkOutput("mult md_start T+2", md_start, 0);
        checkOutput("mult stall T+2", stall, 1);
        tick();
        @(negedge clk); checkOutput("mult stall T+3", stall, 1);
        tick();
        md_end = 1'b1; md_result = 64'hFFFFFFFF_FFFFFFFA;
        @(negedge clk); checkOutput("mult stall T+4", stall, 1);
        checkOutput("mult hi before commit", hi, 32'h1234);
        tick();
        md_end = 1'b0;
        @(negedge clk); checkOutput("mult stall T+5", stall, 0);
        checkOutput("mult hi T+5", hi, 32'hFFFFFFFF);
        checkOutput("mult lo T+5", lo, 32'hFFFFFFFA);

        // DIVU by zero is accepted but never launched
        tick();
        applyStimulus(1'b1, OP_DIVU, 32'd7, 32'd0);
        @(negedge clk); checkOutput("divu/0 stall", stall, 0);
        tick();
        applyStimulus(1'b0, OP_NOP, '0, '0);
        @(negedge clk); checkOutput("divu/0 md_start", md_start, 0);
        checkOutput("divu/0 hi", hi, 32'hFFFFFFFF);

        // DIVU 7/2 with the shortest engine latency
        tick();
        applyStimulus(1'b1, OP_DIVU, 32'd7, 32'd2);
        launchQ.push_back('{1'b0, 1'b1, 32'd7, 32'd2});
        hiloQ.push_back(64'h00000001_00000003);
        @(negedge clk); checkOutput("divu stall T", stall, 1);
        tick();
        applyStimulus(1'b0, OP_NOP, '0, '0);
        @(negedge clk); checkOutput("divu md_start T+1", md_start, 1);
        tick();
        md_end = 1'b1; md_result = 64'h00000001_00000003;
        @(negedge clk); checkOutput("divu stall T+2", stall, 1);
        tick();
        md_end = 1'b0;
        @(negedge clk); checkOutput("divu stall T+3", stall, 0);
        checkOutput("divu hi", hi, 32'd1);
        checkOutput("divu lo", lo, 32'd3);

        // DIV flushed two cycles before completion, MULTU held during DRAIN
        tick();
        applyStimulus(1'b1, OP_DIV, 32'd100, 32'd7);
        launchQ.push_back('{1'b1, 1'b1, 32'd100, 32'd7});
        tick();
        applyStimulus(1'b0, OP_NOP, '0, '0);
        tick();
        flush = 1'b1;
        @(negedge clk); checkOutput("div flush stall", stall, 1);
        tick();
        flush = 1'b0;
        applyStimulus(1'b1, OP_MULTU, 32'd5, 32'd6);
        @(negedge clk); checkOutput("drain stall with request", stall, 1);
        tick();
        md_end = 1'b1; md_result = 64'h0000DEAD_0000BEEF;
        @(negedge clk); checkOutput("drain stall at md_end", stall, 1);
        tick();
        md_end = 1'b0;
        launchQ.push_back('{1'b0, 1'b0, 32'd5, 32'd6});
        hiloQ.push_back(64'h00000000_0000001E);
        @(negedge clk); checkOutput("multu accept stall", stall, 1);
        checkOutput("drain discard hi", hi, 32'd1);
        checkOutput("drain discard lo", lo, 32'd3);
        tick();
        applyStimulus(1'b0, OP_NOP, '0, '0);
        @(negedge clk); checkOutput("multu md_start", md_start, 1);
        tick(); tick();
        md_end = 1'b1; md_result = 64'h00000000_0000001E;
        tick();
        md_end = 1'b0;
        @(negedge clk); checkOutput("multu lo", lo, 32'd30);
        checkOutput("multu stall after", stall, 0);

        // Flush coinciding with md_end discards the result
        tick();
        applyStimulus(1'b1, OP_MULT, 32'd2, 32'd3);
        launchQ.push_back('{1'b1, 1'b0, 32'd2, 32'd3});
        tick();
        applyStimulus(1'b0, OP_NOP, '0, '0);
        tick();
        md_end = 1'b1; flush = 1'b1; md_result = 64'h0000AAAA_0000BBBB;
        tick();
        md_end = 1'b0; flush = 1'b0;
        @(negedge clk); checkOutput("flush+end stall", stall, 0);
        checkOutput("flush+end lo", lo, 32'd30);

        // Reset in the middle of BUSY, then a stale md_end
        tick();
        applyStimulus(1'b1, OP_MULT, 32'd9, 32'd9);
        launchQ.push_back('{1'b1, 1'b0, 32'd9, 32'd9});
        tick();
        applyStimulus(1'b0, OP_NOP, '0, '0);
        tick();
        reset = 1'b1;
        hiloQ.push_back(64'h0);
        @(negedge clk); checkOutput("stall during reset", stall, 0);
        tick();
        @(negedge clk); checkOutput("reset mid-busy lo", lo, 0);
        tick();
        reset = 1'b0;
        @(negedge clk); checkOutput("after reset stall", stall, 0);
        checkOutput("after reset md_start", md_start, 0);
        tick();
        md_end = 1'b1; md_result = 64'h00000077_00000088;
        @(negedge clk); checkOutput("stale md_end stall", stall, 0);
        tick();
        md_end = 1'b0;
        @(negedge clk); checkOutput("stale md_end hi", hi, 0);
        checkOutput("stale md_end lo", lo, 0);

        tick(); tick();
        checkOutput("launch queue drained", launchQ.size(), 0);
        checkOutput("hilo queue drained", hiloQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
